// File: rtl/cu_pkg.sv
// Shared constants and types for the registered ID/EX control unit:
// mode/opcode encodings, exe_cmd encodings, FSM states and the decoded control bundle.
package cu_pkg;

  localparam logic [1:0] MODE_ALU = 2'b00;
  localparam logic [1:0] MODE_MEM = 2'b01;
  localparam logic [1:0] MODE_BR  = 2'b10;
  localparam logic [1:0] MODE_EXT = 2'b11;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_EOR  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_ADD  = 4'b0100;
  localparam logic [3:0] OP_ADC  = 4'b0101;
  localparam logic [3:0] OP_SBC  = 4'b0110;
  localparam logic [3:0] OP_TST  = 4'b1000;
  localparam logic [3:0] OP_CMP  = 4'b1010;
  localparam logic [3:0] OP_ORR  = 4'b1100;
  localparam logic [3:0] OP_MOV  = 4'b1101;
  localparam logic [3:0] OP_MVN  = 4'b1111;
  localparam logic [3:0] OP_LDST = 4'b0100;
  localparam logic [3:0] OP_MUL  = 4'b0000;

  localparam logic [3:0] CMD_NOP = 4'b0000;
  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;
  localparam logic [3:0] CMD_MVN = 4'b1001;
  localparam logic [3:0] CMD_MUL = 4'b1010;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } cu_state_e;

  typedef struct packed {
    logic [3:0] cmd;
    logic       wb_en;
    logic       mem_r_en;
    logic       mem_w_en;
    logic       has_src1;
    logic       b;
    logic       s_out;
    logic       illegal;
    logic       is_mul;
  } cu_ctrl_t;

  localparam cu_ctrl_t CTRL_NOP = '0;

  function automatic cu_ctrl_t illegal_ctrl();
    cu_ctrl_t c;
    c         = CTRL_NOP;
    c.illegal = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/cu_decode.sv
// Purely combinational decode table: mode/opcode/S -> execute-stage control bundle.
module cu_decode
  import cu_pkg::*;
(
  input  logic [1:0] mode,
  input  logic [3:0] opcode,
  input  logic       s_in,
  output cu_ctrl_t   ctrl
);

  always_comb begin
    ctrl = CTRL_NOP;
    case (mode)
      MODE_ALU: begin
        // Common ALU profile; individual opcodes override below.
        ctrl.wb_en    = 1'b1;
        ctrl.has_src1 = 1'b1;
        ctrl.s_out    = s_in;
        case (opcode)
          OP_MOV: begin
            ctrl.cmd      = CMD_MOV;
            ctrl.has_src1 = 1'b0;
          end
          OP_MVN: begin
            ctrl.cmd      = CMD_MVN;
            ctrl.has_src1 = 1'b0;
          end
          OP_ADD: ctrl.cmd = CMD_ADD;
          OP_ADC: ctrl.cmd = CMD_ADC;
          OP_SUB: ctrl.cmd = CMD_SUB;
          OP_SBC: ctrl.cmd = CMD_SBC;
          OP_AND: ctrl.cmd = CMD_AND;
          OP_ORR: ctrl.cmd = CMD_ORR;
          OP_EOR: ctrl.cmd = CMD_EOR;
          OP_CMP: begin
            ctrl.cmd   = CMD_SUB;
            ctrl.wb_en = 1'b0;
            ctrl.s_out = 1'b1;
          end
          OP_TST: begin
            ctrl.cmd   = CMD_AND;
            ctrl.wb_en = 1'b0;
            ctrl.s_out = 1'b1;
          end
          default: ctrl = illegal_ctrl();
        endcase
      end
      MODE_MEM: begin
        if (opcode == OP_LDST) begin
          ctrl.cmd      = CMD_ADD;
          ctrl.has_src1 = 1'b1;
          ctrl.mem_r_en = s_in;
          ctrl.mem_w_en = ~s_in;
          ctrl.wb_en    = s_in;
        end else begin
          ctrl = illegal_ctrl();
        end
      end
      MODE_BR: begin
        ctrl.b = 1'b1;
      end
      MODE_EXT: begin
        if (opcode == OP_MUL) begin
          ctrl.cmd      = CMD_MUL;
          ctrl.wb_en    = 1'b1;
          ctrl.has_src1 = 1'b1;
          ctrl.s_out    = s_in;
          ctrl.is_mul   = 1'b1;
        end else begin
          ctrl = illegal_ctrl();
        end
      end
    endcase
  end

endmodule

// File: rtl/control_unit_seq.sv
// Registered ID/EX control unit with stall/flush/squash and a multi-cycle MUL sequencer.
// Optional performance counters are enabled by defining CU_PERF_COUNT_EN.
//
// Handshake: a decode word transfers on a cycle where in_valid && in_ready && !stall && !flush.
// in_ready drops while the MUL sequencer is busy; the producer must hold its word until it
// transfers. out_valid marks a valid ID/EX control word and has no back-pressure.
module control_unit_seq
  import cu_pkg::*;
#(
  parameter int EXE_CMD_W  = 4,
  parameter int MUL_CYCLES = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [1:0]           mode,
  input  logic [3:0]           opcode,
  input  logic                 s_in,
  input  logic                 cond_pass,
  input  logic                 stall,
  input  logic                 flush,
  output logic                 in_ready,
  output logic                 busy,
  output logic                 out_valid,
  output logic [EXE_CMD_W-1:0] exe_cmd,
  output logic                 wb_en,
  output logic                 mem_r_en,
  output logic                 mem_w_en,
  output logic                 has_src1,
  output logic                 b,
  output logic                 s_out,
  output logic                 illegal,
  output cu_state_e            state_dbg
`ifdef CU_PERF_COUNT_EN
  ,
  output logic [31:0]          perf_issued,
  output logic [31:0]          perf_stall
`endif
);

  localparam int               CNT_W    = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_CYCLES - 1);

  cu_ctrl_t         dec;
  cu_state_e        state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       pend_cmd;
  logic             pend_wb_en;
  logic             pend_has_src1;
  logic             pend_s_out;
  logic             accept;
  logic             take_mul;
  logic             mul_done;

  cu_decode u_decode (
    .mode   (mode),
    .opcode (opcode),
    .s_in   (s_in),
    .ctrl   (dec)
  );

  assign busy      = (state == BUSY);
  // Gated by reset so every output reads 0 while rst is held low.
  assign in_ready  = rst & ~busy;
  assign state_dbg = state;
  assign accept    = in_valid & in_ready & ~stall & ~flush;
  // A squashed MUL never enters the sequencer; it loads like any squashed op.
  assign take_mul  = accept & dec.is_mul & cond_pass;
  assign mul_done  = busy & (cnt == '0) & ~stall & ~flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      cnt           <= '0;
      pend_cmd      <= '0;
      pend_wb_en    <= 1'b0;
      pend_has_src1 <= 1'b0;
      pend_s_out    <= 1'b0;
      out_valid     <= 1'b0;
      exe_cmd       <= '0;
      wb_en         <= 1'b0;
      mem_r_en      <= 1'b0;
      mem_w_en      <= 1'b0;
      has_src1      <= 1'b0;
      b             <= 1'b0;
      s_out         <= 1'b0;
      illegal       <= 1'b0;
    end else if (state == BUSY) begin
      out_valid <= 1'b0;
      wb_en     <= 1'b0;
      mem_r_en  <= 1'b0;
      mem_w_en  <= 1'b0;
      b         <= 1'b0;
      s_out     <= 1'b0;
      illegal   <= 1'b0;
      if (flush) begin
        state <= IDLE;
        cnt   <= '0;
      end else if (!stall) begin
        if (cnt == '0) begin
          state     <= IDLE;
          out_valid <= 1'b1;
          exe_cmd   <= EXE_CMD_W'(pend_cmd);
          wb_en     <= pend_wb_en;
          has_src1  <= pend_has_src1;
          s_out     <= pend_s_out;
        end else begin
          cnt <= cnt - 1'b1;
        end
      end
    end else begin
      if (flush) begin
        out_valid <= 1'b0;
        wb_en     <= 1'b0;
        mem_r_en  <= 1'b0;
        mem_w_en  <= 1'b0;
        b         <= 1'b0;
        s_out     <= 1'b0;
        illegal   <= 1'b0;
      end else if (stall) begin
        // ID/EX register holds its contents.
      end else if (take_mul) begin
        state         <= BUSY;
        cnt           <= CNT_LOAD;
        pend_cmd      <= dec.cmd;
        pend_wb_en    <= dec.wb_en;
        pend_has_src1 <= dec.has_src1;
        pend_s_out    <= dec.s_out;
        out_valid     <= 1'b0;
        wb_en         <= 1'b0;
        mem_r_en      <= 1'b0;
        mem_w_en      <= 1'b0;
        b             <= 1'b0;
        s_out         <= 1'b0;
        illegal       <= 1'b0;
      end else if (accept) begin
        // Failed condition still issues a slot, but with all side effects suppressed.
        out_valid <= 1'b1;
        exe_cmd   <= EXE_CMD_W'(dec.cmd);
        has_src1  <= dec.has_src1;
        illegal   <= dec.illegal;
        wb_en     <= dec.wb_en & cond_pass;
        mem_r_en  <= dec.mem_r_en & cond_pass;
        mem_w_en  <= dec.mem_w_en & cond_pass;
        b         <= dec.b & cond_pass;
        s_out     <= dec.s_out & cond_pass;
      end else begin
        out_valid <= 1'b0;
        wb_en     <= 1'b0;
        mem_r_en  <= 1'b0;
        mem_w_en  <= 1'b0;
        b         <= 1'b0;
        s_out     <= 1'b0;
        illegal   <= 1'b0;
      end
    end
  end

`ifdef CU_PERF_COUNT_EN
  logic issue_evt;
  assign issue_evt = mul_done | (~busy & accept & ~take_mul);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_issued <= '0;
      perf_stall  <= '0;
    end else begin
      if (issue_evt) perf_issued <= perf_issued + 32'd1;
      if (stall | busy) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: doc/control_unit_seq.md
Name: control_unit_seq

Overview:
- Registered, parametrised successor to the ID-stage control decoder.
- Decodes mode/opcode/S into execute-stage control and holds the result in an ID/EX control register, with stall, flush and condition squash.
- Adds a multi-cycle MUL sequencer that back-pressures the fetch/decode front end.
- Sits between ID decode fields and the EXE stage.

Parameters:
- EXE_CMD_W, 4, exe_cmd width; must be ≥4; upper bits zero-filled.
- MUL_CYCLES, 3, execute occupancy of MUL in cycles; must be ≥1.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low
- in_valid  in  1  decode fields valid
- mode  in  2  instruction mode field
- opcode  in  4  instruction opcode field
- s_in  in  1  S / L bit
- cond_pass  in  1  condition check result for current instruction
- stall  in  1  hazard stall; hold the ID/EX register
- flush  in  1  branch-taken flush
- in_ready  out  1  block can accept; equals !busy
- busy  out  1  MUL sequencer occupied
- out_valid  out  1  ID/EX control register valid
- exe_cmd  out  EXE_CMD_W  ALU command
- wb_en, mem_r_en, mem_w_en, has_src1, b, s_out, illegal  out  1 each  registered controls

Behaviour:
- Reset (rst=0, async): all outputs 0; state IDLE; counter 0; pending-MUL register cleared.
- Decode, combinational, then registered (latency 1):
  - mode 00, ALU ops (opcode→cmd):
    - MOV 1101→0001, has_src1=0
    - MVN 1111→1001, has_src1=0
    - ADD 0100→0010
    - ADC 0101→0011
    - SUB 0010→0100
    - SBC 0110→0101
    - AND 0000→0110
    - ORR 1100→0111
    - EOR 0001→1000
    - CMP 1010→0100, wb_en=0, s_out=1
    - TST 1000→0110, wb_en=0, s_out=1
  - mode 00, other ALU ops: wb_en=1, has_src1=1, s_out=s_in.
  - mode 00, other opcodes: NOP: cmd 0000, wb_en=0, has_src1=0, illegal=1.
  - mode 01, opcode 0100: cmd 0010, has_src1=1.
    - s_in=0: STR, mem_w_en=1, wb_en=0.
    - s_in=1: LDR, mem_r_en=1, wb_en=1.
  - mode 01, other opcodes: NOP with illegal=1.
  - mode 10: b=1, wb_en=0, has_src1=0, cmd 0000.
  - mode 11, opcode 0000: MUL, cmd 1010, wb_en=1, has_src1=1, s_out=s_in; sequenced, see below.
  - mode 11, other opcodes: NOP with illegal=1.
- accept = in_valid & in_ready & !stall & !flush.
- Register update priority:
  - flush: out_valid and all enables cleared.
  - else stall: hold all outputs.
  - else accept of non-MUL: load decode, out_valid=1.
  - else: out_valid=0 and enables cleared.
- Squash: cond_pass=0 on accept gives out_valid=1 with wb_en, mem_r_en, mem_w_en, b, s_out forced 0; exe_cmd and has_src1 still loaded.
- FSM, IDLE→BUSY:
  - Transition on accept of MUL with cond_pass=1: save decode in pending register, cnt=MUL_CYCLES-1, busy=1.
  - Squashed MUL (cond_pass=0) is treated as a non-MUL squash; no BUSY.
- BUSY:
  - out_valid=0 each cycle.
  - cnt decrements when !stall.
  - When cnt==0 and !stall: load pending MUL into the output register (out_valid=1) and return to IDLE; in_ready rises the same cycle.
  - When cnt==0 and stall: remain BUSY and hold.
  - flush in BUSY: abort to IDLE, nothing emitted, out_valid=0.
- MUL latency: MUL_CYCLES+1 cycles from accept to out_valid.
- Inputs are ignored while busy; in_valid while busy is the producer's responsibility to hold.

Optional Feature:
- Macro CU_PERF_COUNT_EN.
- Defined:
  - Extra outputs perf_issued[31:0] counts cycles with out_valid rising due to any load.
  - perf_stall[31:0] counts cycles with stall|busy.
  - Both wrap at 2^32 and are reset by rst.
- Undefined: ports and counters absent; no other behaviour changes.

Decomposition:
- Shared package cu_pkg holds:
  - mode constants MODE_ALU/MODE_MEM/MODE_BR/MODE_EXT
  - opcode constants
  - exe_cmd constants including CMD_MUL=1010
  - FSM state enum {IDLE, BUSY}
- One natural sub-module: cu_decode, purely combinational decode table, instantiated inside; FSM and register stay in the top.

Test Plan:
- ADD (mode00, op0100, s_in=1, cond_pass=1) → next cycle out_valid=1, exe_cmd=0010, wb_en=1, s_out=1, has_src1=1.
- CMP then STR (mode01, op0100, s_in=0) back-to-back → CMP: wb_en=0, s_out=1, cmd 0100; STR next cycle: mem_w_en=1, wb_en=0, cmd 0010.
- LDR with cond_pass=0 → out_valid=1, mem_r_en=0, wb_en=0, exe_cmd=0010.
- MUL with MUL_CYCLES=3 → busy and in_ready low 3 cycles with out_valid=0; cycle 4 out_valid=1, cmd 1010, wb_en=1; stall in cycle 2 extends by 1.
- Stall for 2 cycles after ADD → outputs hold; flush with stall → out_valid=0 next cycle; flush during MUL BUSY → IDLE, no MUL emitted.
- Async rst assert mid-BUSY (between edges) → all outputs 0 immediately, in_ready=1 after release; mode00 op0011 → illegal=1, wb_en=0.
